// File: rtl/parking_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | parking_pkg: command/state types and car-count limits shared by the  |
// | parking-lot sensor pattern generator.   Revision: 1.0                |
// +----------------------------------------------------------------------+
package parking_pkg;

    localparam int                   CAR_CNT_W   = 4;
    localparam logic [CAR_CNT_W-1:0] CAR_CNT_MAX = 4'd15;

    typedef enum logic [1:0] {
        CMD_ENTER = 2'b00,
        CMD_EXIT  = 2'b01,
        CMD_ABORT = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PH1  = 3'd1,
        ST_PH2  = 3'd2,
        ST_PH3  = 3'd3,
        ST_GAP  = 3'd4
    } gen_state_t;

    // {a,b} per phase; every step of every pattern flips exactly one beam.
    function automatic logic [1:0] phase_ab(input cmd_t cmd, input gen_state_t st);
        logic [1:0] ab;
        ab = 2'b00;
        case (st)
            ST_PH1:  ab = (cmd == CMD_EXIT)  ? 2'b01 : 2'b10;
            ST_PH2:  ab = 2'b11;
            ST_PH3:  ab = (cmd == CMD_ENTER) ? 2'b01 : 2'b10;
            default: ab = 2'b00;
        endcase
        return ab;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | phase_timer: 8-bit loadable down-counter, expire while count is 1.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] count,
    output logic       expire
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != 8'd0) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign expire = (count_q == 8'd1);

endmodule
`default_nettype wire

// File: rtl/sensor_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sensor_pattern_gen: drives Gray-coded A/B beam patterns for ENTER,   |
// | EXIT and ABORT (ABORT only with ABORT_PATTERN_EN). Revision: 1.0     |
// +----------------------------------------------------------------------+
module sensor_pattern_gen
    import parking_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_cmd,
    output logic       req_ready,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] expected_cars
);

    localparam logic [7:0] c_hold_cycles = 8'(HOLD_CYCLES);
    localparam logic [7:0] c_gap_cycles  = 8'(GAP_CYCLES);

    gen_state_t           state_q, state_d;
    cmd_t                 cmd_q, cmd_d;
    logic [1:0]           ab_q, ab_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [CAR_CNT_W-1:0] cars_q, cars_d;

    logic       tmr_load;
    logic [7:0] tmr_val;
    logic [7:0] tmr_count;
    logic       tmr_expire;
    cmd_t       req_cmd_e;

    function automatic logic cmd_has_pattern(input cmd_t c);
`ifdef ABORT_PATTERN_EN
        return (c != CMD_RSVD);
`else
        return (c == CMD_ENTER) || (c == CMD_EXIT);
`endif
    endfunction

    assign req_cmd_e = cmd_t'(req_cmd);

    phase_timer u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count),
        .expire   (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        err_d    = 1'b0;
        cars_d   = cars_q;
        tmr_load = 1'b0;
        tmr_val  = c_hold_cycles;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (cmd_has_pattern(req_cmd_e)) begin
                        state_d  = ST_PH1;
                        cmd_d    = req_cmd_e;
                        tmr_load = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_PH1: begin
                if (tmr_expire) begin
                    state_d  = ST_PH2;
                    tmr_load = 1'b1;
                end
            end
            ST_PH2: begin
                if (tmr_expire) begin
                    state_d  = ST_PH3;
                    tmr_load = 1'b1;
                end
            end
            ST_PH3: begin
                if (tmr_expire) begin
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = c_gap_cycles;
                end
            end
            ST_GAP: begin
                if (tmr_expire) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // done is registered, so flag the cycle whose next count will be the last one.
        done_d = (state_d == ST_GAP) &&
                 (tmr_load ? (tmr_val == 8'd1) : (tmr_count == 8'd2));

        if (done_d) begin
            if (cmd_q == CMD_ENTER && cars_q != CAR_CNT_MAX) begin
                cars_d = cars_q + 1'b1;
            end else if (cmd_q == CMD_EXIT && cars_q != '0) begin
                cars_d = cars_q - 1'b1;
            end
        end

        ab_d = phase_ab(cmd_d, state_d);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_ENTER;
            ab_q    <= 2'b00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cars_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            ab_q    <= ab_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cars_q  <= cars_d;
        end
    end

    assign req_ready     = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign a             = ab_q[1];
    assign b             = ab_q[0];
    assign done          = done_q;
    assign err           = err_q;
    assign expected_cars = cars_q;

endmodule
`default_nettype wire

// File: tb/tb_sensor_pattern_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sensor_pattern_gen: directed bench, HOLD_CYCLES=2, GAP_CYCLES=1.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sensor_pattern_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_cmd;
    logic       req_ready, a, b, busy, done, err;
    logic [3:0] expected_cars;

    int checks = 0;
    int errors = 0;
    logic       poke_busy;

    // Reference parking-lot counter fed only by the beam outputs.
    logic [3:0] model_cars;
    logic [5:0] hist;
    logic [1:0] prev_ab;

    localparam logic [13:0] SEQ_ENTER = {2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00};
    localparam logic [13:0] SEQ_EXIT  = {2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00};
    localparam logic [13:0] SEQ_ABORT = {2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00};

    always #5 clk = ~clk;

    sensor_pattern_gen #(
        .HOLD_CYCLES (2),
        .GAP_CYCLES  (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_cmd       (req_cmd),
        .req_ready     (req_ready),
        .a             (a),
        .b             (b),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .expected_cars (expected_cars)
    );

    always @(negedge clk) begin
        if (!reset) begin
            model_cars <= 4'd0;
            hist       <= 6'd0;
            prev_ab    <= 2'b00;
        end else if ({a, b} != prev_ab) begin
            prev_ab <= {a, b};
            if ({a, b} != 2'b00) begin
                hist <= {hist[3:0], a, b};
            end else begin
                if (hist == 6'b10_11_01 && model_cars != 4'd15) model_cars <= model_cars + 4'd1;
                else if (hist == 6'b01_11_10 && model_cars != 4'd0) model_cars <= model_cars - 4'd1;
                hist <= 6'd0;
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] c);
        @(negedge clk);
        chk("ready_before_cmd", {7'd0, req_ready}, 8'd1);
        req_valid = 1'b1;
        req_cmd   = c;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic expect_pattern(input logic [13:0] seq, input logic [3:0] cars_exp, input string tag);
        logic [1:0] exp_ab;
        logic [1:0] last;
        last = 2'b00;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (poke_busy && i == 1) begin
                req_valid = 1'b1;
                req_cmd   = 2'b11;
            end
            if (poke_busy && i == 5) req_valid = 1'b0;
            exp_ab = seq[13-2*i -: 2];
            chk({tag, "_ab"},   {6'd0, a, b}, {6'd0, exp_ab});
            chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
            chk({tag, "_done"}, {7'd0, done}, {7'd0, (i == 6)});
            chk({tag, "_err"},  {7'd0, err},  8'd0);
            chk({tag, "_gray"}, {7'd0, ($countones({a, b} ^ last) <= 1)}, 8'd1);
            last = {a, b};
        end
        chk({tag, "_cars"}, {4'd0, expected_cars}, {4'd0, cars_exp});
        @(negedge clk);
        chk({tag, "_idle_ready"}, {7'd0, req_ready}, 8'd1);
        chk({tag, "_idle_busy"},  {7'd0, busy}, 8'd0);
        chk({tag, "_idle_done"},  {7'd0, done}, 8'd0);
        chk({tag, "_idle_ab"},    {6'd0, a, b}, 8'd0);
    endtask

    task automatic expect_err(input logic [3:0] cars_exp, input string tag);
        @(negedge clk);
        chk({tag, "_err"},   {7'd0, err}, 8'd1);
        chk({tag, "_busy"},  {7'd0, busy}, 8'd0);
        chk({tag, "_ab"},    {6'd0, a, b}, 8'd0);
        chk({tag, "_ready"}, {7'd0, req_ready}, 8'd1);
        chk({tag, "_cars"},  {4'd0, expected_cars}, {4'd0, cars_exp});
        @(negedge clk);
        chk({tag, "_err_clr"}, {7'd0, err}, 8'd0);
        chk({tag, "_ab2"},     {6'd0, a, b}, 8'd0);
    endtask

    task automatic do_abort(input logic [3:0] cars_exp, input string tag);
        send(2'b10);
`ifdef ABORT_PATTERN_EN
        expect_pattern(SEQ_ABORT, cars_exp, tag);
`else
        expect_err(cars_exp, tag);
`endif
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_cmd   = 2'b00;
        poke_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ab",   {6'd0, a, b}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_err",  {7'd0, err},  8'd0);
        chk("rst_cars", {4'd0, expected_cars}, 8'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_release_ready", {7'd0, req_ready}, 8'd1);

        // First ENTER also holds req_valid with a reserved command while busy.
        poke_busy = 1'b1;
        send(2'b00);
        expect_pattern(SEQ_ENTER, 4'd1, "enter1");
        poke_busy = 1'b0;

        send(2'b01);
        expect_pattern(SEQ_EXIT, 4'd0, "exit1");
        send(2'b01);
        expect_pattern(SEQ_EXIT, 4'd0, "exit_at0");

        send(2'b11);
        expect_err(4'd0, "rsvd");

        for (int i = 0; i < 16; i++) begin
            send(2'b00);
            expect_pattern(SEQ_ENTER, (i >= 14) ? 4'd15 : 4'(i + 1), "enter_sat");
        end

        do_abort(4'd15, "abort1");

        // Reset during PH2 of an ENTER.
        send(2'b00);
        repeat (3) @(negedge clk);
        chk("midrst_ph2_ab", {6'd0, a, b}, 8'h03);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_ab",   {6'd0, a, b}, 8'd0);
        chk("midrst_busy", {7'd0, busy}, 8'd0);
        chk("midrst_done", {7'd0, done}, 8'd0);
        chk("midrst_cars", {4'd0, expected_cars}, 8'd0);
        @(negedge clk);
        chk("midrst_done2", {7'd0, done}, 8'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {7'd0, req_ready}, 8'd1);

        for (int i = 0; i < 5; i++) begin
            send(2'b00);
            expect_pattern(SEQ_ENTER, 4'(i + 1), "loop_enter");
        end
        do_abort(4'd5, "loop_abort1");
        do_abort(4'd5, "loop_abort2");
        for (int i = 0; i < 3; i++) begin
            send(2'b01);
            expect_pattern(SEQ_EXIT, 4'(4 - i), "loop_exit");
        end
        @(negedge clk);
        chk("loop_model_cars", {4'd0, model_cars}, 8'd2);
        chk("loop_dut_cars",   {4'd0, expected_cars}, {4'd0, model_cars});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sensor_pattern_gen.md
SENSOR_PATTERN_GEN -- requirements
Module: sensor_pattern_gen

Interface
REQ-001 Parameter: HOLD_CYCLES, default 4, number of clocks each non-idle sensor phase is held (legal range 1..255).
REQ-002 Parameter: GAP_CYCLES, default 2, number of clocks of a=b=0 driven after a pattern before the next request is accepted (legal range 1..255).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  1  command request valid.
REQ-006 req_cmd  input  2  command: 00 ENTER, 01 EXIT, 10 ABORT, 11 reserved.
REQ-007 req_ready  output  1  block can accept a command.
REQ-008 a  output  1  sensor A drive (outer beam), registered.
REQ-009 b  output  1  sensor B drive (inner beam), registered.
REQ-010 busy  output  1  pattern or gap in progress.
REQ-011 done  output  1  one-cycle pulse at pattern completion.
REQ-012 err  output  1  one-cycle pulse on rejected command.
REQ-013 expected_cars  output  4  model occupancy after all completed patterns.

Function
REQ-014 Handshake: a command is accepted on an edge where req_valid=1 and req_ready=1; req_ready SHALL be 1 only in IDLE.
REQ-015 States: IDLE, PH1, PH2, PH3, GAP; IDLE drives a,b=00.
REQ-016 ENTER: a,b sequence PH1=10, PH2=11, PH3=01, then GAP=00.
REQ-017 EXIT: a,b sequence PH1=01, PH2=11, PH3=10, then GAP=00.
REQ-018 ABORT (car backs out): a,b sequence PH1=10, PH2=11, PH3=10, then GAP=00.
REQ-019 Latency: command accepted at edge N -> a,b show PH1 value after edge N; each PHx held exactly HOLD_CYCLES clocks; GAP held exactly GAP_CYCLES clocks.
REQ-020 done SHALL pulse for one clock in the last GAP cycle; the next clock is IDLE with req_ready=1.
REQ-021 expected_cars SHALL update in the done cycle: ENTER +1 saturating at 15, EXIT -1 saturating at 0, ABORT unchanged.
REQ-022 EXIT at expected_cars=0 and ENTER at 15 SHALL still generate the full pattern; only the count saturates.
REQ-023 Reserved command (11) accepted in IDLE: err pulses one clock after acceptance, no pattern, state stays IDLE, expected_cars unchanged.
REQ-024 busy=1 in PH1..GAP, 0 in IDLE; req_valid while busy is ignored (not queued, no err).
REQ-025 a and b SHALL never change in the same clock edge (single-bit-change, Gray sequence).

Reset
REQ-026 While reset=0 at an edge: state IDLE, a=0, b=0, busy=0, done=0, err=0, req_ready=1 after release, expected_cars=0, hold counter cleared.
REQ-027 Reset asserted mid-pattern SHALL abandon the pattern at the next edge with a,b=00 and no done pulse.

Configuration
REQ-028 Macro ABORT_PATTERN_EN: defined -> ABORT behaves per REQ-018.
REQ-029 ABORT_PATTERN_EN undefined -> ABORT treated as reserved per REQ-023 (err pulse, no pattern).

Structure
REQ-030 Shared package parking_pkg SHALL hold: command enum cmd_t (CMD_ENTER, CMD_EXIT, CMD_ABORT, CMD_RSVD), generator state enum, CAR_CNT_W=4, CAR_CNT_MAX=15.
REQ-031 One sub-module phase_timer: loadable down-counter (8-bit) with load and expire outputs, shared by phase and gap timing.

Verification
REQ-032 Reset, then ENTER with HOLD_CYCLES=2, GAP_CYCLES=1 -> a,b = 10,10,11,11,01,01,00 starting at the clock after acceptance; done in the 00 cycle; expected_cars 0->1.
REQ-033 From expected_cars=1, EXIT -> a,b = 01,11,10,00 sequence; expected_cars 1->0; a second EXIT -> full pattern, expected_cars stays 0.
REQ-034 16 consecutive ENTERs -> expected_cars saturates at 15; 16th pattern still fully generated.
REQ-035 ABORT with macro defined -> 10,11,10,00 and expected_cars unchanged; without macro -> err pulse one clock, a,b stay 00.
REQ-036 Reset=0 asserted during PH2 of ENTER -> next edge a,b=00, busy=0, no done, expected_cars=0.
REQ-037 Loopback into the existing parking-lot counter: 5 ENTER, 2 ABORT, 3 EXIT -> counter no_cars equals expected_cars = 2.
